// File: rtl/shift_register_pkg.sv
// Shared definitions for the configurable shift register / sample history buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_register_pkg;

    // Operating mode, sampled on every rising clk edge together with shift_en.
    typedef enum logic [1:0] {
        MODE_SHIFT_FWD = 2'd0,  // stage 0 takes data_in, contents move towards DEPTH-1
        MODE_ROTATE    = 2'd1,  // last stage wraps into stage 0, data_in ignored
        MODE_SHIFT_REV = 2'd2,  // stage DEPTH-1 takes data_in, contents move towards 0
        MODE_HOLD      = 2'd3   // no change even when shift_en is high
    } mode_e;

endpackage

// File: rtl/shift_tap_mux.sv
// Combinational read-tap selector over a flattened multi-stage bus.
// Latency: zero cycles; tap_out/tap_valid follow data_flat/valid/tap_sel directly.
// Backpressure: none; pure selector, no handshake.
//
// Ports:
//   data_flat  stage i at bits [i*WIDTH +: WIDTH]
//   valid      per-stage valid bit
//   tap_sel    stage index to read
//   tap_out    data of the selected stage (0 when tap_sel >= DEPTH)
//   tap_valid  valid bit of the selected stage (0 when tap_sel >= DEPTH)
module shift_tap_mux #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int TAP_W = $clog2(DEPTH)
) (
    input  logic [DEPTH*WIDTH-1:0] data_flat,
    input  logic [DEPTH-1:0]       valid,
    input  logic [TAP_W-1:0]       tap_sel,
    output logic [WIDTH-1:0]       tap_out,
    output logic                   tap_valid
);

    // Compare against every legal index; an index beyond the last stage
    // matches nothing and so falls through to the zero defaults.
    always_comb begin
        tap_out   = '0;
        tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TAP_W'(i)) begin
                tap_out   = data_flat[i*WIDTH +: WIDTH];
                tap_valid = valid[i];
            end
        end
    end

endmodule

// File: rtl/shift_register_ctrl.sv
// Configurable delay line / sample history buffer with per-stage valid and occupancy count.
// Latency: stages, valid bits, count, full and empty update one clk after the qualifying edge; tap read is combinational.
// Backpressure: none; every enabled edge advances the register, the oldest entry simply falls off the end.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   shift_en       advance the register this cycle according to mode
//   mode           0 forward shift, 1 rotate, 2 reverse shift, 3 hold
//   clear          synchronous clear of data, valid and count (highest priority)
//   data_in        entry written by forward/reverse shift, with in_valid
//   tap_sel        stage index for tap_out/tap_valid
//   reg_out_flat   all stages, stage i at bits [i*WIDTH +: WIDTH]
//   valid_out      per-stage valid bits
//   tap_out        stage[tap_sel], tap_valid its valid bit
//   count          number of valid stages, full/empty decoded from it
module shift_register_ctrl
    import shift_register_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int TAP_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   shift_en,
    input  logic [1:0]             mode,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   in_valid,
    input  logic [TAP_W-1:0]       tap_sel,
    output logic [DEPTH*WIDTH-1:0] reg_out_flat,
    output logic [DEPTH-1:0]       valid_out,
    output logic [WIDTH-1:0]       tap_out,
    output logic                   tap_valid,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   empty
);

    localparam int FLAT_W = DEPTH * WIDTH;

    logic [FLAT_W-1:0] data_q, data_d;
    logic [DEPTH-1:0]  vld_q,  vld_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    mode_e             mode_s;

    assign mode_s = mode_e'(mode);

    // Next state. The whole register is kept as one flat vector so each
    // mode is a single concatenation; stage 0 is the least significant slice.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        cnt_d  = cnt_q;
        if (clear) begin
            data_d = '0;
            vld_d  = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            case (mode_s)
                MODE_SHIFT_FWD: begin
                    data_d = {data_q[FLAT_W-WIDTH-1:0], data_in};
                    vld_d  = {vld_q[DEPTH-2:0], in_valid};
                    // Modular arithmetic: a full register taking a valid entry
                    // while dropping a valid one nets to zero even if the
                    // intermediate sum would not fit in CNT_W bits.
                    cnt_d  = cnt_q + CNT_W'(in_valid) - CNT_W'(vld_q[DEPTH-1]);
                end
                MODE_ROTATE: begin
                    data_d = {data_q[FLAT_W-WIDTH-1:0], data_q[FLAT_W-1 -: WIDTH]};
                    vld_d  = {vld_q[DEPTH-2:0], vld_q[DEPTH-1]};
                end
                MODE_SHIFT_REV: begin
                    data_d = {data_in, data_q[FLAT_W-1:WIDTH]};
                    vld_d  = {in_valid, vld_q[DEPTH-1:1]};
                    cnt_d  = cnt_q + CNT_W'(in_valid) - CNT_W'(vld_q[0]);
                end
                default: begin
                    // MODE_HOLD: keep everything as is
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            vld_q  <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
        end
    end

    assign reg_out_flat = data_q;
    assign valid_out    = vld_q;
    assign count        = cnt_q;
    assign full         = (cnt_q == CNT_W'(DEPTH));
    assign empty        = (cnt_q == '0);

    shift_tap_mux #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .TAP_W (TAP_W)
    ) u_tap_mux (
        .data_flat (data_q),
        .valid     (vld_q),
        .tap_sel   (tap_sel),
        .tap_out   (tap_out),
        .tap_valid (tap_valid)
    );

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Bench for shift_register_ctrl: a DEPTH=4 instance (power-of-2) and a DEPTH=5
// instance (out-of-range tap indices reachable) share one stimulus stream and
// are both compared every negedge against an array-based model.
module tb_shift_register_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, shift_en, clear, in_valid;
    logic [1:0] mode;
    logic [7:0] data_in;
    logic [1:0] tap_sel_a;
    logic [2:0] tap_sel_b;

    logic [31:0] flat_a;
    logic [3:0]  vout_a;
    logic [7:0]  tap_a;
    logic        tv_a, full_a, empty_a;
    logic [2:0]  cnt_a;

    logic [39:0] flat_b;
    logic [4:0]  vout_b;
    logic [7:0]  tap_b;
    logic        tv_b, full_b, empty_b;
    logic [2:0]  cnt_b;

    shift_register_ctrl #(.WIDTH(8), .DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .mode(mode), .clear(clear),
        .data_in(data_in), .in_valid(in_valid), .tap_sel(tap_sel_a),
        .reg_out_flat(flat_a), .valid_out(vout_a), .tap_out(tap_a), .tap_valid(tv_a),
        .count(cnt_a), .full(full_a), .empty(empty_a)
    );

    shift_register_ctrl #(.WIDTH(8), .DEPTH(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .mode(mode), .clear(clear),
        .data_in(data_in), .in_valid(in_valid), .tap_sel(tap_sel_b),
        .reg_out_flat(flat_b), .valid_out(vout_b), .tap_out(tap_b), .tap_valid(tv_b),
        .count(cnt_b), .full(full_b), .empty(empty_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: stage contents and valid bits as plain arrays, index = stage number.
    int         dep [2] = '{4, 5};
    logic [7:0] md  [2][8];
    logic       mv  [2][8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic mzero();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) begin
                md[k][i] = '0;
                mv[k][i] = 1'b0;
            end
    endtask

    task automatic mstep(input int k);
        int d;
        logic [7:0] t;
        logic tv;
        d = dep[k];
        if (!rst_n || clear) begin
            for (int i = 0; i < d; i++) begin
                md[k][i] = '0;
                mv[k][i] = 1'b0;
            end
        end else if (shift_en) begin
            case (mode)
                2'd0: begin
                    for (int i = d - 1; i > 0; i--) begin
                        md[k][i] = md[k][i-1];
                        mv[k][i] = mv[k][i-1];
                    end
                    md[k][0] = data_in;
                    mv[k][0] = in_valid;
                end
                2'd1: begin
                    t  = md[k][d-1];
                    tv = mv[k][d-1];
                    for (int i = d - 1; i > 0; i--) begin
                        md[k][i] = md[k][i-1];
                        mv[k][i] = mv[k][i-1];
                    end
                    md[k][0] = t;
                    mv[k][0] = tv;
                end
                2'd2: begin
                    for (int i = 0; i < d - 1; i++) begin
                        md[k][i] = md[k][i+1];
                        mv[k][i] = mv[k][i+1];
                    end
                    md[k][d-1] = data_in;
                    mv[k][d-1] = in_valid;
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [63:0] exp_flat(input int k);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < dep[k]; i++) r[i*8 +: 8] = md[k][i];
        return r;
    endfunction

    function automatic logic [63:0] exp_vld(input int k);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < dep[k]; i++) r[i] = mv[k][i];
        return r;
    endfunction

    function automatic int exp_cnt(input int k);
        int c;
        c = 0;
        for (int i = 0; i < dep[k]; i++) c += int'(mv[k][i]);
        return c;
    endfunction

    task automatic compare_inst(input int k, input string p,
                                input logic [63:0] flat, input logic [63:0] vout,
                                input logic [63:0] tap, input logic tv, input int cnt,
                                input logic full, input logic empty, input int sel);
        int c;
        logic [63:0] etap;
        logic etv;
        c    = exp_cnt(k);
        etap = (sel < dep[k]) ? 64'(md[k][sel]) : 64'd0;
        etv  = (sel < dep[k]) ? mv[k][sel] : 1'b0;
        chk({p, "_flat"},  flat, exp_flat(k));
        chk({p, "_valid"}, vout, exp_vld(k));
        chk({p, "_count"}, 64'(cnt), 64'(c));
        chk({p, "_full"},  64'(full), 64'(c == dep[k]));
        chk({p, "_empty"}, 64'(empty), 64'(c == 0));
        chk({p, "_tap"},   tap, etap);
        chk({p, "_tapv"},  64'(tv), 64'(etv));
    endtask

    // Single compare process: both instances every falling edge.
    always @(negedge clk) begin
        compare_inst(0, "a", 64'(flat_a), 64'(vout_a), 64'(tap_a), tv_a, int'(cnt_a),
                     full_a, empty_a, int'(tap_sel_a));
        compare_inst(1, "b", 64'(flat_b), 64'(vout_b), 64'(tap_b), tv_b, int'(cnt_b),
                     full_b, empty_b, int'(tap_sel_b));
    end

    // One clocked operation; returns one time unit after the following negedge.
    task automatic cyc(input logic se, input logic [1:0] m, input logic cl,
                       input logic [7:0] d, input logic v);
        shift_en = se;
        mode     = m;
        clear    = cl;
        data_in  = d;
        in_valid = v;
        @(posedge clk);
        mstep(0);
        mstep(1);
        @(negedge clk);
        #1;
    endtask

    task automatic fill_1234();
        cyc(1'b1, 2'd0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 2'd0, 1'b0, 8'h11, 1'b1);
        cyc(1'b1, 2'd0, 1'b0, 8'h22, 1'b1);
        cyc(1'b1, 2'd0, 1'b0, 8'h33, 1'b1);
        cyc(1'b1, 2'd0, 1'b0, 8'h44, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; shift_en = 1'b0; mode = 2'd0; clear = 1'b0;
        data_in = '0; in_valid = 1'b0; tap_sel_a = '0; tap_sel_b = '0;
        mzero();
        @(negedge clk);
        #1;
        chk("rst_flat", 64'(flat_a), 64'h0);
        chk("rst_count", 64'(cnt_a), 64'd0);
        chk("rst_empty", 64'(empty_a), 64'd1);
        chk("rst_full", 64'(full_a), 64'd0);
        rst_n = 1'b1;

        // Fill
        fill_1234();
        chk("t1_flat", 64'(flat_a), 64'h11223344);
        chk("t1_count", 64'(cnt_a), 64'd4);
        chk("t1_full", 64'(full_a), 64'd1);
        chk("t1_tap0", 64'(tap_a), 64'h44);
        chk("t1_tapv", 64'(tv_a), 64'd1);
        chk("pin_model_fill", exp_flat(0), 64'h11223344);

        // Full steady state, then a bubble enters
        cyc(1'b1, 2'd0, 1'b0, 8'h55, 1'b1);
        chk("t2_stage3", 64'(flat_a[31:24]), 64'h22);
        chk("t2_stage0", 64'(flat_a[7:0]), 64'h55);
        chk("t2_count", 64'(cnt_a), 64'd4);
        cyc(1'b1, 2'd0, 1'b0, 8'h66, 1'b0);
        chk("t2_count_b", 64'(cnt_a), 64'd3);
        chk("t2_valid", 64'(vout_a), 64'b1110);
        chk("t2_full", 64'(full_a), 64'd0);

        // Rotate ignores data_in
        fill_1234();
        cyc(1'b1, 2'd1, 1'b0, 8'hFF, 1'b1);
        cyc(1'b1, 2'd1, 1'b0, 8'hFF, 1'b1);
        chk("t3_flat", 64'(flat_a), 64'h33441122);
        chk("t3_count", 64'(cnt_a), 64'd4);
        chk("pin_model_rot", exp_flat(0), 64'h33441122);

        // Reverse drain
        fill_1234();
        for (int j = 0; j < 4; j++) begin
            cyc(1'b1, 2'd2, 1'b0, 8'h00, 1'b0);
            chk("t4_count", 64'(cnt_a), 64'(3 - j));
            if (j == 0) chk("t4_stage0", 64'(flat_a[7:0]), 64'h33);
        end
        chk("t4_empty", 64'(empty_a), 64'd1);

        // Clear beats shift, then hold for five cycles
        cyc(1'b1, 2'd0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 2'd0, 1'b0, 8'hAA, 1'b1);
        cyc(1'b1, 2'd0, 1'b0, 8'hBB, 1'b1);
        cyc(1'b1, 2'd0, 1'b1, 8'hCC, 1'b1);
        chk("t5_clr_flat", 64'(flat_a), 64'h0);
        chk("t5_clr_count", 64'(cnt_a), 64'd0);
        cyc(1'b1, 2'd0, 1'b0, 8'hAA, 1'b1);
        cyc(1'b1, 2'd0, 1'b0, 8'hBB, 1'b1);
        for (int j = 0; j < 5; j++) begin
            if (j % 2 == 0) cyc(1'b0, 2'($urandom), 1'b0, 8'($urandom), 1'b1);
            else            cyc(1'b1, 2'd3, 1'b0, 8'($urandom), 1'b1);
        end
        chk("t5_hold_flat", 64'(flat_a), 64'h0000AABB);
        chk("t5_hold_valid", 64'(vout_a), 64'b0011);
        chk("t5_hold_count", 64'(cnt_a), 64'd2);

        // Async reset between edges
        cyc(1'b1, 2'd0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 2'd0, 1'b0, 8'h01, 1'b1);
        cyc(1'b1, 2'd0, 1'b0, 8'h02, 1'b1);
        cyc(1'b1, 2'd0, 1'b0, 8'h03, 1'b1);
        chk("t6_count_pre", 64'(cnt_a), 64'd3);
        #2;
        rst_n = 1'b0;
        mzero();
        #1;
        chk("t6_rst_flat", 64'(flat_a), 64'h0);
        chk("t6_rst_count", 64'(cnt_a), 64'd0);
        chk("t6_rst_empty", 64'(empty_a), 64'd1);
        chk("t6_rst_valid", 64'(vout_a), 64'h0);
        @(posedge clk);
        mstep(0);
        mstep(1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 2'd0, 1'b0, 8'h77, 1'b1);
        chk("t6_count_post", 64'(cnt_a), 64'd1);
        chk("t6_valid_post", 64'(vout_a), 64'b0001);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            tap_sel_a = 2'($urandom);
            tap_sel_b = 3'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                mzero();
                #2;
                rst_n = 1'b1;
            end
            cyc($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 31) == 0,
                8'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_register_ctrl.md
Name: shift_register_ctrl

Overview:
- Parametrised successor to the team's plain fixed-size shift register.
- Adds per-stage valid tracking, shift enable, a 2-bit mode (forward shift, rotate, reverse shift, hold) and a synchronous clear.
- Adds a registered occupancy count with full/empty flags and a selectable read tap.
- Sits in the PWM loop datapath as a configurable delay line / sample history buffer; all stages are exposed on a flattened parallel bus.

Parameters:
- WIDTH, 8, bits per stage
- DEPTH, 8, number of stages; legal range DEPTH >= 2
- TAP_W, $clog2(DEPTH), width of tap_sel (derived; do not override)
- CNT_W, $clog2(DEPTH+1), width of count (derived; do not override)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset; the only reset
- shift_en  in  1  advance the register this cycle per mode
- mode  in  2  0=SHIFT_FWD, 1=ROTATE, 2=SHIFT_REV, 3=HOLD
- clear  in  1  synchronous clear; zeroes data, valid and count
- data_in  in  WIDTH  entry written in SHIFT_FWD/SHIFT_REV
- in_valid  in  1  valid bit accompanying data_in
- tap_sel  in  TAP_W  stage index for tap_out
- reg_out_flat  out  DEPTH*WIDTH  stage i occupies bits [i*WIDTH +: WIDTH]
- valid_out  out  DEPTH  per-stage valid bit
- tap_out  out  WIDTH  stage[tap_sel]
- tap_valid  out  1  valid[tap_sel]
- count  out  CNT_W  number of valid stages (registered)
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Reset (rst_n low, async): all stages, valid bits and count go to 0 immediately.
  - Reset outputs: reg_out_flat=0, valid_out=0, tap_out=0, tap_valid=0, count=0, full=0, empty=1.
  - Reset asserted mid-operation discards all contents.
  - First update occurs on the first rising clk after rst_n deasserts.
- Priority each rising edge: clear > (shift_en & mode) > hold.
  - clear=1: stages, valid and count all set to 0, regardless of shift_en.
  - shift_en=0, or mode=HOLD: no state change.
- SHIFT_FWD:
  - stage[i] <= stage[i-1] for i = 1..DEPTH-1; stage[0] <= data_in.
  - valid bits move identically, with valid[0] <= in_valid.
  - count <= count + in_valid - valid[DEPTH-1].
- ROTATE:
  - stage[0] <= stage[DEPTH-1]; others as SHIFT_FWD; valid bits rotate identically.
  - count unchanged; data_in and in_valid ignored.
- SHIFT_REV:
  - stage[i] <= stage[i+1] for i = 0..DEPTH-2; stage[DEPTH-1] <= data_in.
  - valid[DEPTH-1] <= in_valid.
  - count <= count + in_valid - valid[0].
- Invalid stages hold whatever data was shifted into them; that data is not forced to zero except by clear/reset.
- Latency: stage/valid/count/full/empty update one cycle after the qualifying edge.
  - reg_out_flat and valid_out are direct register outputs.
  - tap_out/tap_valid are combinational reads of the current registers, with no extra latency.
- tap_sel >= DEPTH (only possible for non-power-of-2 DEPTH): tap_out=0, tap_valid=0.
- Invariant, checked every cycle: count == popcount(valid_out); count never exceeds DEPTH and never underflows.
- full/empty are decoded from the registered count.
- Simultaneous in_valid=1 while the last valid bit shifts out leaves count unchanged (e.g. a full register stays full).
- mode changes take effect on the same edge they are sampled; there is no pipeline across modes.

Decomposition:
- Shared include/package shift_register_pkg:
  - mode encodings MODE_SHIFT_FWD=2'd0, MODE_ROTATE=2'd1, MODE_SHIFT_REV=2'd2, MODE_HOLD=2'd3
  - a clog2 helper function if the toolflow needs one
- One natural sub-module, shift_tap_mux: WIDTH/DEPTH-parametrised combinational selector.
  - Input: flat bus + valid vector + tap_sel.
  - Output: tap_out, tap_valid, with the out-of-range zeroing rule.
- Count update logic stays in the top module.

Test Plan:
1. Reset/fill (WIDTH=8, DEPTH=4): after reset, SHIFT_FWD data_in 8'h11, 8'h22, 8'h33, 8'h44 with in_valid=1 -> reg_out_flat=32'h11223344, count=4, full=1; tap_sel=0 gives 8'h44, tap_valid=1.
2. Full steady-state: from test 1, shift 8'h55 valid -> stage3=8'h22, stage0=8'h55, count stays 4; shift 8'h66 with in_valid=0 -> count=3, valid_out=4'b1110, full=0.
3. Rotate: from 32'h11223344 full, two ROTATE cycles -> 32'h33441122, count=4; data_in=8'hFF is ignored.
4. Reverse/drain: from full 32'h11223344, four SHIFT_REV cycles with in_valid=0 -> count 3,2,1,0, empty=1 at end; first cycle stage0=8'h33.
5. Priority/hold: clear=1 with shift_en=1 mid-fill -> all zero, count=0 next cycle; shift_en=0 or mode=HOLD for 5 cycles -> outputs unchanged.
6. Async reset mid-operation: assert rst_n low between clock edges while count=3 -> outputs zero with no clock edge; after release, a single valid shift gives count=1.
